hue_div_ctrl: RTL and testbench

Sequencer for the hue divide step. It sits between the RGB compare/select stage, which emits a signed dividend, an unsigned divisor and a function tag every valid cycle, and the hue offset/scale stage. It buffers incoming operand sets in a small FIFO and drives one shared radix-2 restoring divider, one quotient bit per cycle. It returns a fixed-point quotient with its function tag over a valid/ready handshake, and flags dropped inputs and grey (zero-divisor) pixels.

---
 rtl/hue_pkg.sv | 30 +++
 rtl/hue_div_fifo.sv | 66 ++++++
 rtl/hue_div_ctrl.sv | 149 ++++++++++++++
 tb/tb_hue_div_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hue_pkg.sv
// Shared definitions for the hue pipeline: operand width, function tags,
// divider sequencer states and the buffered operand-set payload.
package hue_pkg;

    localparam int unsigned DIV_W = 9;
    localparam int unsigned FN_W  = 2;

    localparam logic [FN_W-1:0] FN_NONE  = 2'd0;
    localparam logic [FN_W-1:0] FN_RED   = 2'd1;
    localparam logic [FN_W-1:0] FN_GREEN = 2'd2;
    localparam logic [FN_W-1:0] FN_BLUE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [DIV_W-1:0] dividend;
        logic [DIV_W-1:0] divisor;
        logic [FN_W-1:0]  func;
    } div_op_t;

    // Magnitude of a two's-complement operand; -2^(DIV_W-1) maps to 2^(DIV_W-1).
    function automatic logic [DIV_W-1:0] abs_dividend(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? (~x + DIV_W'(1)) : x;
    endfunction

endpackage

// File: rtl/hue_div_fifo.sv
// Synchronous FIFO for operand sets; full/empty are registered flags.
module hue_div_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CNW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNW-1:0]   count;
    logic [CNW-1:0]   count_nxt_c;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;
    assign rd_data   = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        if (push_ok_c && !pop_ok_c) begin
            count_nxt_c = count + CNW'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_nxt_c = count - CNW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNW'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

endmodule

// File: rtl/hue_div_ctrl.sv
// Hue divide sequencer: buffers operand sets and runs a shared radix-2
// restoring divider producing a signed fixed-point quotient per set.
module hue_div_ctrl
    import hue_pkg::*;
#(
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_W-1:0]     i_dividend,
    input  logic [DIV_W-1:0]     i_divisor,
    input  logic [FN_W-1:0]      i_function,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [FRAC_BITS+1:0] o_quotient,
    output logic [FN_W-1:0]      o_function,
    output logic                 o_zero,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overflow
);

    localparam int unsigned N     = FRAC_BITS + 1;
    localparam int unsigned QW    = FRAC_BITS + 2;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned REM_W = DIV_W + 1;
    localparam int unsigned OP_W  = $bits(div_op_t);
    localparam logic [N-1:0] SAT_MAG = N'(1) << FRAC_BITS;

    div_op_t          in_op_c;
    div_op_t          head_c;
    logic             push_c;
    logic             pop_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DIV_W-1:0] mag_in_c;

    div_state_t       state;
    logic [REM_W-1:0] rem;
    logic [N-1:0]     quo;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] divisor_r;
    logic             sign_r;
    logic             sat_r;
    logic [FN_W-1:0]  fn_r;

    logic             ge_c;
    logic [REM_W-1:0] diff_c;
    logic [N-1:0]     quo_c;
    logic [N-1:0]     mag_c;
    logic [QW-1:0]    qext_c;
    logic [QW-1:0]    signed_c;

    assign in_op_c  = '{dividend: i_dividend, divisor: i_divisor, func: i_function};
    assign push_c   = i_valid && o_ready;
    assign pop_c    = (state == ST_IDLE) && !fifo_empty;
    assign mag_in_c = abs_dividend(head_c.dividend);
    assign o_ready  = !fifo_full;

    hue_div_fifo #(
        .WIDTH (OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push    (push_c),
        .wr_data (in_op_c),
        .pop     (pop_c),
        .rd_data (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // One restoring step: compare, subtract, shift the quotient bit in.
    always_comb begin
        ge_c     = rem >= REM_W'(divisor_r);
        diff_c   = ge_c ? (rem - REM_W'(divisor_r)) : rem;
        quo_c    = N'({quo, ge_c});
        mag_c    = sat_r ? SAT_MAG : quo_c;
        qext_c   = QW'(mag_c);
        signed_c = sign_r ? (QW'(0) - qext_c) : qext_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            divisor_r  <= '0;
            sign_r     <= 1'b0;
            sat_r      <= 1'b0;
            fn_r       <= FN_NONE;
            o_quotient <= '0;
            o_function <= FN_NONE;
            o_zero     <= 1'b0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (i_valid && !o_ready) begin
                o_overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fn_r      <= head_c.func;
                        sign_r    <= head_c.dividend[DIV_W-1];
                        divisor_r <= head_c.divisor;
                        if (head_c.divisor == '0) begin
                            o_quotient <= '0;
                            o_function <= head_c.func;
                            o_zero     <= 1'b1;
                            o_valid    <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            // Remainder starts at |dividend|; the <<FRAC_BITS is implied by the shifts.
                            rem   <= REM_W'(mag_in_c);
                            quo   <= '0;
                            cnt   <= CNT_W'(N);
                            sat_r <= mag_in_c > head_c.divisor;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem <= REM_W'({diff_c, 1'b0});
                    quo <= quo_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        o_quotient <= signed_c;
                        o_function <= fn_r;
                        o_zero     <= 1'b0;
                        o_valid    <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hue_div_ctrl.sv
// Self-checking bench for hue_div_ctrl: directed vectors plus randomized
// traffic checked against an arithmetic reference of the truncating divide.
module tb_hue_div_ctrl;
    import hue_pkg::*;

    localparam int FRAC = 8;
    localparam int N    = FRAC + 1;
    localparam int LAT  = N + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] dividend;
    logic [8:0] divisor;
    logic [1:0] func;
    logic       valid;
    logic       rdy_in;
    logic       dut_ready;
    logic [9:0] quot;
    logic [1:0] fn_o;
    logic       zero_o;
    logic       valid_o;
    logic       ovf_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [9:0] q;
        logic [1:0] fn;
        logic       z;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hue_div_ctrl #(
        .FRAC_BITS  (FRAC),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .i_function (func),
        .i_valid    (valid),
        .o_ready    (dut_ready),
        .o_quotient (quot),
        .o_function (fn_o),
        .o_zero     (zero_o),
        .o_valid    (valid_o),
        .i_ready    (rdy_in),
        .o_overflow (ovf_o)
    );

    // trunc(a * 2^FRAC / d) toward zero, magnitude capped at 2^FRAC; 0 for d == 0.
    function automatic int ref_quot(int a, int d);
        int m;
        if (d == 0) return 0;
        m = ((a < 0) ? -a : a) * (1 << FRAC) / d;
        if (m > (1 << FRAC)) m = 1 << FRAC;
        return (a < 0) ? -m : m;
    endfunction

    function automatic exp_t ref_result(logic [8:0] dvd, logic [8:0] dvs, logic [1:0] fn);
        exp_t e;
        e.q  = 10'(ref_quot(int'($signed(dvd)), int'(dvs)));
        e.fn = fn;
        e.z  = (dvs == 9'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_op(input bit allow_zero, output logic [8:0] a, output logic [8:0] d,
                          output logic [1:0] f);
        int dd;
        int aa;
        if (allow_zero && ($urandom_range(0, 3) == 0)) dd = 0;
        else dd = int'($urandom_range(1, 511));
        aa = int'($urandom_range(0, (dd < 256) ? dd : 256));
        if (aa == 256 || $urandom_range(0, 1) == 1) a = 9'(-aa);
        else a = 9'(aa);
        d = 9'(dd);
        f = 2'($urandom_range(0, 3));
    endtask

    // Single operand set with i_ready high: checks latency, result and handshake.
    task automatic send_check(input logic [8:0] dvd, input logic [8:0] dvs, input logic [1:0] fn,
                              input logic [9:0] exp_q10, input logic exp_z, input int exp_lat,
                              input string name);
        int lat;
        dividend = dvd; divisor = dvs; func = fn; valid = 1'b1; rdy_in = 1'b1;
        n_tests++;
        if (dut_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_before_push: got %b expected 1", name, dut_ready);
        end
        tick();
        valid = 1'b0;
        lat = 1;
        while (valid_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (quot !== exp_q10) begin
            n_fail++; $display("FAIL %s quotient: got %h expected %h", name, quot, exp_q10);
        end
        n_tests++;
        if (fn_o !== fn) begin
            n_fail++; $display("FAIL %s function: got %0d expected %0d", name, fn_o, fn);
        end
        n_tests++;
        if (zero_o !== exp_z) begin
            n_fail++; $display("FAIL %s zero: got %b expected %b", name, zero_o, exp_z);
        end
        tick();
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL %s valid_after_handshake: got %b expected 0", name, valid_o);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if (dut_ready !== 1'b1) begin n_fail++; $display("FAIL %s o_ready: got %b expected 1", name, dut_ready); end
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s o_valid: got %b expected 0", name, valid_o); end
        n_tests++;
        if (quot !== 10'd0) begin n_fail++; $display("FAIL %s o_quotient: got %h expected 000", name, quot); end
        n_tests++;
        if (fn_o !== 2'd0) begin n_fail++; $display("FAIL %s o_function: got %0d expected 0", name, fn_o); end
        n_tests++;
        if (zero_o !== 1'b0) begin n_fail++; $display("FAIL %s o_zero: got %b expected 0", name, zero_o); end
        n_tests++;
        if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL %s o_overflow: got %b expected 0", name, ovf_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; rdy_in = 1'b0;
        dividend = 9'd17; divisor = 9'd33; func = FN_BLUE;
        tick();
        tick();
        rst = 1'b0; valid = 1'b0;
        tick();
        check_reset_values("reset");
    endtask

    task automatic test_directed();
        send_check(9'd64,   9'd128, FN_RED,   10'd128,  1'b0, LAT, "nominal");
        send_check(9'h1C0,  9'd192, FN_GREEN, 10'h3AB,  1'b0, LAT, "neg_trunc");
        send_check(9'd255,  9'd255, FN_BLUE,  10'd256,  1'b0, LAT, "unity");
        send_check(9'h100,  9'd256, FN_RED,   10'h300,  1'b0, LAT, "min_dividend");
        send_check(9'h1FF,  9'd2,   FN_GREEN, 10'h380,  1'b0, LAT, "neg_half");
        send_check(9'd1,    9'd511, FN_BLUE,  10'd0,    1'b0, LAT, "tiny");
        send_check(9'd200,  9'd100, FN_RED,   10'd256,  1'b0, LAT, "saturate");
    endtask

    task automatic test_grey();
        send_check(9'd0,   9'd0,   FN_NONE, 10'd0,   1'b1, 2,   "grey");
        send_check(9'd100, 9'd200, FN_RED,  10'd128, 1'b0, LAT, "after_grey");
        send_check(9'h1FB, 9'd0,   FN_BLUE, 10'd0,   1'b1, 2,   "grey_neg");
    endtask

    task automatic test_backpressure();
        logic [8:0] a;
        logic [8:0] d;
        logic [1:0] f;
        int guard;
        rdy_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gen_op(1'b1, a, d, f);
            dividend = a; divisor = d; func = f; valid = 1'b1;
            n_tests++;
            if (dut_ready !== (i < 5)) begin
                n_fail++; $display("FAIL bp_ready item %0d: got %b expected %b", i, dut_ready, (i < 5));
            end
            if (i < 5) exp_q.push_back(ref_result(a, d, f));
            tick();
            if (i == 4) begin
                n_tests++;
                if (dut_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_ready_low_after_E: got %b expected 0", dut_ready);
                end
            end
        end
        valid = 1'b0;
        n_tests++;
        if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b expected 1", ovf_o); end
        guard = 0;
        while (valid_o !== 1'b1 && guard < 40) begin tick(); guard++; end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (valid_o !== 1'b1 || quot !== exp_q[0].q || fn_o !== exp_q[0].fn || zero_o !== exp_q[0].z) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b q=%h fn=%0d z=%b expected v=1 q=%h fn=%0d z=%b",
                         k, valid_o, quot, fn_o, zero_o, exp_q[0].q, exp_q[0].fn, exp_q[0].z);
            end
            tick();
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 600) begin
            rdy_in = 1'($urandom_range(0, 1));
            if (valid_o === 1'b1) begin
                n_tests++;
                if (quot !== exp_q[0].q || fn_o !== exp_q[0].fn || zero_o !== exp_q[0].z) begin
                    n_fail++;
                    $display("FAIL bp_drain: got q=%h fn=%0d z=%b expected q=%h fn=%0d z=%b",
                             quot, fn_o, zero_o, exp_q[0].q, exp_q[0].fn, exp_q[0].z);
                end
                if (rdy_in) void'(exp_q.pop_front());
            end
            tick();
            guard++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        rdy_in = 1'b1;
        tick();
        n_tests++;
        if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL bp_overflow_sticky: got %b expected 1", ovf_o); end
    endtask

    task automatic test_back_to_back();
        rdy_in = 1'b1;
        fork
            begin : drv
                logic [8:0] a;
                logic [8:0] d;
                logic [1:0] f;
                int g;
                for (int i = 0; i < 8; i++) begin
                    gen_op(1'b0, a, d, f);
                    dividend = a; divisor = d; func = f; valid = 1'b1;
                    g = 0;
                    while (dut_ready !== 1'b1 && g < 200) begin tick(); g++; end
                    exp_q.push_back(ref_result(a, d, f));
                    tick();
                end
                valid = 1'b0;
            end
            begin : mon
                int got;
                int last;
                int g;
                got = 0; last = -1; g = 0;
                while (got < 8 && g < 300) begin
                    if (valid_o === 1'b1) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL b2b_unexpected_result: got q=%h expected none", quot);
                        end else begin
                            if (quot !== exp_q[0].q || fn_o !== exp_q[0].fn || zero_o !== exp_q[0].z) begin
                                n_fail++;
                                $display("FAIL b2b_result %0d: got q=%h fn=%0d z=%b expected q=%h fn=%0d z=%b",
                                         got, quot, fn_o, zero_o, exp_q[0].q, exp_q[0].fn, exp_q[0].z);
                            end
                            void'(exp_q.pop_front());
                        end
                        if (last >= 0) begin
                            n_tests++;
                            if (cyc - last !== LAT) begin
                                n_fail++; $display("FAIL b2b_interval %0d: got %0d expected %0d", got, cyc - last, LAT);
                            end
                        end
                        last = cyc;
                        got++;
                    end
                    tick();
                    g++;
                end
                n_tests++;
                if (got != 8) begin
                    n_fail++; $display("FAIL b2b_timeout: got %0d results expected 8", got);
                end
            end
        join
        exp_q.delete();
    endtask

    task automatic test_reset_mid_div();
        logic [8:0] a;
        logic [8:0] d;
        logic [1:0] f;
        exp_t e;
        int stale;
        rdy_in = 1'b1;
        gen_op(1'b0, a, d, f);
        dividend = a; divisor = d; func = f; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("mid_div_reset");
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid_o !== 1'b0) stale++;
            tick();
        end
        n_tests++;
        if (stale != 0) begin n_fail++; $display("FAIL mid_div_stale_valid: got %0d cycles expected 0", stale); end
        gen_op(1'b0, a, d, f);
        e = ref_result(a, d, f);
        send_check(a, d, f, e.q, e.z, LAT, "after_reset");
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rdy_in = 1'b1;
        dividend = '0; divisor = '0; func = '0;
        test_reset();
        test_directed();
        test_grey();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
